trap_arbiter: RTL and testbench
===============================

Name: trap_arbiter

Overview:
- Sits between the commit stage and the trap CSR unit.
- Each cycle, decides whether the committing instruction raises an exception, or whether a pending interrupt is taken at that instruction boundary.
- Selects the target privilege (M or S) from the delegation registers, drives the trap commit strobe and trap value/cause/PC into the CSR trap unit, and issues the fetch redirect to the trap vector.
- Also owns the WFI sleep state.

Parameters:
- XLEN, 64, datapath width.
- PC_RESET, 64'h0, unused by trap logic; value driven on redirect_pc_o at reset.

Ports:
- clk_i  in  1  core clock
- arst_ni  in  1  asynchronous active-low reset
- commit_valid_i  in  1  head instruction presents for commit this cycle
- commit_ready_o  out  1  arbiter accepts commit; 1 only in RUN
- commit_exc_i  in  1  committing instruction carries a synchronous exception
- commit_wfi_i  in  1  committing instruction is WFI (no exception)
- commit_cause_i  in  6  exception code
- commit_pc_i  in  XLEN  PC of committing instruction
- commit_tval_i  in  XLEN  exception value
- priv_i  in  2  current privilege (0=U, 1=S, 3=M)
- mstatus_mie_i, mstatus_sie_i  in  1 each  global interrupt enables
- mip_i, mie_i, mideleg_i, medeleg_i  in  XLEN each  CSR values
- mtvec_i, stvec_i  in  XLEN each  trap vector CSRs
- trap_valid_o  out  1  one-cycle strobe: trap committed to CSR unit
- trap_m_o, trap_s_o  out  1 each  target privilege, one-hot while trap_valid_o
- trap_async_o  out  1  1 = interrupt
- trap_pc_o, trap_value_o, trap_cause_o  out  XLEN each  epc, tval, cause code (bit 63 = 0; the CSR unit inserts async)
- redirect_valid_o  out  1  fetch redirect request, held until acknowledged
- redirect_pc_o  out  XLEN  redirect target
- flush_ack_i  in  1  pipeline flushed and redirect consumed
- wfi_sleep_o  out  1  core stalled in WFI

Behaviour:
- Reset (arst_ni=0, asynchronous): state=RUN. trap_valid_o, trap_m_o, trap_s_o, trap_async_o, redirect_valid_o and wfi_sleep_o are 0. trap_pc_o, trap_value_o and trap_cause_o are 0. redirect_pc_o=PC_RESET. Reset asserted in any state aborts it with no trap strobe.
- Interrupt eligibility (combinational): pend = mip_i & mie_i, considering bits 11, 3, 7, 9, 1, 5 only.
  - Non-delegated bit (mideleg=0): enabled if priv_i<3, or priv_i==3 and mstatus_mie_i.
  - Delegated bit: enabled if priv_i<1, or priv_i==1 and mstatus_sie_i; never taken when priv_i==3.
  - Priority, highest first: MEI 11, MSI 3, MTI 7, SEI 9, SSI 1, STI 5.
- Exception target: S if medeleg_i[commit_cause_i] and priv_i!=3; otherwise M.
- Trap vector: base = tvec & ~3. If tvec[1:0]==1 and async, target = base + 4*cause; otherwise base. tvec is mtvec_i for M, stvec_i for S.
- States:
  - RUN:
    - On commit_valid_i, an enabled interrupt wins over an exception: epc = commit_pc_i, tval = 0, and the instruction is not retired.
    - Otherwise commit_exc_i: epc = commit_pc_i, tval = commit_tval_i.
    - Either case → ISSUE.
    - Otherwise commit_wfi_i → WFI, and latch commit_pc_i+4 as wake PC.
    - Otherwise stay in RUN.
  - ISSUE (exactly 1 cycle):
    - trap_valid_o=1 with registered trap fields. redirect_valid_o=1, redirect_pc_o = vector.
    - → FLUSH.
  - FLUSH:
    - redirect_valid_o and redirect_pc_o held stable; trap_valid_o=0.
    - → RUN on the flush_ack_i cycle. If ack already arrives in ISSUE, go to RUN directly after ISSUE.
  - WFI:
    - wfi_sleep_o=1. Exit when pend != 0, regardless of global enables.
    - If some pend bit is eligible: take the interrupt with epc = wake PC → ISSUE.
    - Otherwise: redirect_valid_o=1, redirect_pc_o = wake PC → FLUSH, with no trap strobe.
- Latency: commit in cycle N → trap_valid_o and redirect_valid_o in cycle N+1. No other trap can be accepted before the ack.
- commit_ready_o=0 in ISSUE, FLUSH and WFI. commit_valid_i in those states is ignored.
- Simultaneous events:
  - commit_exc_i together with commit_wfi_i: treated as an exception.
  - mip changes during ISSUE/FLUSH: ignored until RUN.
  - The chosen cause is frozen at the decision cycle.

Test Plan:
- priv=U, commit_exc_i=1, cause=8, medeleg[8]=1, stvec=0x8000_1000 → ISSUE next cycle: trap_s_o=1, trap_pc_o=commit_pc, trap_cause_o=8, redirect_pc_o=0x8000_1000. redirect held until flush_ack_i, commit_ready_o=0 meanwhile.
- priv=M, MIE=1, mip=mie=0x888, mtvec=0x100|1, commit_valid_i → MEI chosen: trap_m_o=1, trap_async_o=1, cause=11, redirect_pc_o=0x12C, tval=0.
- priv=M, mideleg=0x222, pend=0x020 only → no trap; instruction commits normally, commit_ready_o stays 1.
- WFI at PC 0x2000, MIE=0, priv=M, then mip[7]=mie[7]=1 → wfi_sleep_o drops, no trap_valid_o, redirect_pc_o=0x2004.
- WFI at PC 0x2000, priv=S, SIE=1, mideleg[9]=1, SEI arrives → trap_s_o=1, cause=9, trap_pc_o=0x2004.
- Assert arst_ni low during FLUSH → all outputs return to reset values immediately, state RUN, no trap_valid_o after release.

Source files
------------

// File: rtl/trap_arbiter_if.sv
// -----------------------------------------------------------------------------
// trap_arbiter_if
//   Groups the commit handshake, the trap strobe/fields toward the CSR trap
//   unit, the fetch redirect handshake and the WFI sleep flag.
//   Signal suffixes (_i/_o) are named from the arbiter's point of view.
//
//   commit_*      : head-of-ROB instruction presented for commit
//   trap_*        : one-cycle trap commit strobe and its epc/tval/cause
//   redirect_*    : fetch redirect request, held until flush_ack_i
//   wfi_sleep_o   : core parked in WFI
//
//   Modports:
//     slave  - the arbiter
//     master - the surrounding core (commit stage / fetch / CSR unit)
// -----------------------------------------------------------------------------
interface trap_arbiter_if #(
  parameter int XLEN = 64
);
  logic            commit_valid_i;
  logic            commit_ready_o;
  logic            commit_exc_i;
  logic            commit_wfi_i;
  logic [5:0]      commit_cause_i;
  logic [XLEN-1:0] commit_pc_i;
  logic [XLEN-1:0] commit_tval_i;

  logic            trap_valid_o;
  logic            trap_m_o;
  logic            trap_s_o;
  logic            trap_async_o;
  logic [XLEN-1:0] trap_pc_o;
  logic [XLEN-1:0] trap_value_o;
  logic [XLEN-1:0] trap_cause_o;

  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_ack_i;

  logic            wfi_sleep_o;

  modport slave (
    input  commit_valid_i, commit_exc_i, commit_wfi_i, commit_cause_i,
           commit_pc_i, commit_tval_i, flush_ack_i,
    output commit_ready_o, trap_valid_o, trap_m_o, trap_s_o, trap_async_o,
           trap_pc_o, trap_value_o, trap_cause_o, redirect_valid_o,
           redirect_pc_o, wfi_sleep_o
  );

  modport master (
    output commit_valid_i, commit_exc_i, commit_wfi_i, commit_cause_i,
           commit_pc_i, commit_tval_i, flush_ack_i,
    input  commit_ready_o, trap_valid_o, trap_m_o, trap_s_o, trap_async_o,
           trap_pc_o, trap_value_o, trap_cause_o, redirect_valid_o,
           redirect_pc_o, wfi_sleep_o
  );
endinterface

// File: rtl/trap_arbiter.sv
// -----------------------------------------------------------------------------
// trap_arbiter
//   Decides, at each commit, whether the committing instruction traps
//   (synchronous exception) or a pending interrupt is taken at that boundary.
//   Picks the target privilege from the delegation CSRs, strobes the trap into
//   the CSR unit, redirects fetch to the trap vector and owns the WFI sleep.
//
//   Ports:
//     clk_i, arst_ni            : clock, asynchronous active-low reset
//     bus (trap_arbiter_if)     : commit / trap / redirect / wfi_sleep signals
//     priv_i                    : current privilege (0=U, 1=S, 3=M)
//     mstatus_mie_i/_sie_i      : global interrupt enables
//     mip_i, mie_i              : pending / enabled interrupt bits
//     mideleg_i, medeleg_i      : interrupt / exception delegation to S
//     mtvec_i, stvec_i          : trap vector bases (mode in bits [1:0])
// -----------------------------------------------------------------------------
module trap_arbiter #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  trap_arbiter_if.slave   bus,
  input  logic [1:0]      priv_i,
  input  logic            mstatus_mie_i,
  input  logic            mstatus_sie_i,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mideleg_i,
  input  logic [XLEN-1:0] medeleg_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] stvec_i
);

  // Only the six standard M/S interrupt lines participate (bits 1,3,5,7,9,11).
  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'hAAA);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2,
    S_WFI   = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_commit_ready;
  logic            r_trap_valid;
  logic            r_trap_m;
  logic            r_trap_s;
  logic            r_trap_async;
  logic [XLEN-1:0] r_trap_pc;
  logic [XLEN-1:0] r_trap_value;
  logic [XLEN-1:0] r_trap_cause;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_wfi_sleep;
  logic [XLEN-1:0] r_wake_pc;

  logic [XLEN-1:0] w_pend;
  logic [XLEN-1:0] w_elig;
  logic            w_irq_take;
  logic [5:0]      w_irq_code;
  logic            w_irq_to_s;
  logic            w_exc_to_s;
  logic            w_ld_s;
  logic [5:0]      w_ld_code;
  logic [XLEN-1:0] w_ld_tval;
  logic [XLEN-1:0] w_ld_epc;
  logic [XLEN-1:0] w_ld_vec;

  // Vectored mode (tvec[1:0]==1) only offsets asynchronous traps.
  function automatic logic [XLEN-1:0] trap_vector(input logic [XLEN-1:0] tvec,
                                                  input logic            is_async,
                                                  input logic [5:0]      code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (is_async && (tvec[1:0] == 2'b01))
      trap_vector = base + (XLEN'(code) << 2);
    else
      trap_vector = base;
  endfunction

  assign w_pend = mip_i & mie_i & IRQ_MASK;

  // A delegated interrupt is only visible below S (or in S with SIE);
  // a non-delegated one is visible below M (or in M with MIE).
  always_comb begin
    w_elig = '0;
    for (int b = 0; b < XLEN; b++) begin
      if (IRQ_MASK[b]) begin
        if (mideleg_i[b])
          w_elig[b] = w_pend[b] && ((priv_i == 2'd0) || ((priv_i == 2'd1) && mstatus_sie_i));
        else
          w_elig[b] = w_pend[b] && ((priv_i != 2'd3) || mstatus_mie_i);
      end
    end
  end

  always_comb begin
    w_irq_take = 1'b1;
    w_irq_code = 6'd0;
    if      (w_elig[11]) w_irq_code = 6'd11;
    else if (w_elig[3])  w_irq_code = 6'd3;
    else if (w_elig[7])  w_irq_code = 6'd7;
    else if (w_elig[9])  w_irq_code = 6'd9;
    else if (w_elig[1])  w_irq_code = 6'd1;
    else if (w_elig[5])  w_irq_code = 6'd5;
    else                 w_irq_take = 1'b0;
  end

  assign w_irq_to_s = mideleg_i[w_irq_code];
  assign w_exc_to_s = medeleg_i[bus.commit_cause_i] && (priv_i != 2'd3);

  // Fields loaded on a trap decision; interrupts win over the exception.
  // Out of WFI only the interrupt path ever loads, with the wake PC as epc.
  assign w_ld_s    = w_irq_take ? w_irq_to_s : w_exc_to_s;
  assign w_ld_code = w_irq_take ? w_irq_code : bus.commit_cause_i;
  assign w_ld_tval = w_irq_take ? '0 : bus.commit_tval_i;
  assign w_ld_epc  = (r_state == S_WFI) ? r_wake_pc : bus.commit_pc_i;
  assign w_ld_vec  = trap_vector(w_ld_s ? stvec_i : mtvec_i, w_irq_take, w_ld_code);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state          <= S_RUN;
      r_commit_ready   <= 1'b1;
      r_trap_valid     <= 1'b0;
      r_trap_m         <= 1'b0;
      r_trap_s         <= 1'b0;
      r_trap_async     <= 1'b0;
      r_trap_pc        <= '0;
      r_trap_value     <= '0;
      r_trap_cause     <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= PC_RESET;
      r_wfi_sleep      <= 1'b0;
      r_wake_pc        <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.commit_valid_i) begin
            if (w_irq_take || bus.commit_exc_i) begin
              r_state          <= S_ISSUE;
              r_commit_ready   <= 1'b0;
              r_trap_valid     <= 1'b1;
              r_trap_m         <= ~w_ld_s;
              r_trap_s         <= w_ld_s;
              r_trap_async     <= w_irq_take;
              r_trap_pc        <= w_ld_epc;
              r_trap_value     <= w_ld_tval;
              r_trap_cause     <= XLEN'(w_ld_code);
              r_redirect_valid <= 1'b1;
              r_redirect_pc    <= w_ld_vec;
            end else if (bus.commit_wfi_i) begin
              r_state        <= S_WFI;
              r_commit_ready <= 1'b0;
              r_wfi_sleep    <= 1'b1;
              r_wake_pc      <= bus.commit_pc_i + XLEN'(4);
            end
          end
        end
        S_ISSUE: begin
          r_trap_valid <= 1'b0;
          r_trap_m     <= 1'b0;
          r_trap_s     <= 1'b0;
          r_trap_async <= 1'b0;
          if (bus.flush_ack_i) begin
            r_state          <= S_RUN;
            r_commit_ready   <= 1'b1;
            r_redirect_valid <= 1'b0;
          end else begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (bus.flush_ack_i) begin
            r_state          <= S_RUN;
            r_commit_ready   <= 1'b1;
            r_redirect_valid <= 1'b0;
          end
        end
        S_WFI: begin
          // Any pending+enabled line wakes the core, even if globally masked.
          if (|w_pend) begin
            r_wfi_sleep      <= 1'b0;
            r_redirect_valid <= 1'b1;
            if (w_irq_take) begin
              r_state       <= S_ISSUE;
              r_trap_valid  <= 1'b1;
              r_trap_m      <= ~w_ld_s;
              r_trap_s      <= w_ld_s;
              r_trap_async  <= 1'b1;
              r_trap_pc     <= w_ld_epc;
              r_trap_value  <= w_ld_tval;
              r_trap_cause  <= XLEN'(w_ld_code);
              r_redirect_pc <= w_ld_vec;
            end else begin
              r_state       <= S_FLUSH;
              r_redirect_pc <= r_wake_pc;
            end
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign bus.commit_ready_o   = r_commit_ready;
  assign bus.trap_valid_o     = r_trap_valid;
  assign bus.trap_m_o         = r_trap_m;
  assign bus.trap_s_o         = r_trap_s;
  assign bus.trap_async_o     = r_trap_async;
  assign bus.trap_pc_o        = r_trap_pc;
  assign bus.trap_value_o     = r_trap_value;
  assign bus.trap_cause_o     = r_trap_cause;
  assign bus.redirect_valid_o = r_redirect_valid;
  assign bus.redirect_pc_o    = r_redirect_pc;
  assign bus.wfi_sleep_o      = r_wfi_sleep;

endmodule

// File: tb/tb_trap_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trap_arbiter
//   Scoreboard bench: the driver predicts each redirect event from the
//   privileged-architecture trap rules and queues it; a monitor pops and
//   compares whenever a new redirect appears.
// -----------------------------------------------------------------------------
module tb_trap_arbiter;
  localparam int          XLEN     = 64;
  localparam logic [63:0] PC_RESET = 64'h8000_0000;
  localparam logic [63:0] IRQ_BITS = 64'hAAA;

  logic clk = 1'b0;
  logic arst_ni = 1'b0;
  always #5 clk = ~clk;

  trap_arbiter_if #(.XLEN(XLEN)) bus();

  logic [1:0]  priv;
  logic        m_mie, m_sie;
  logic [63:0] mip, mie, mideleg, medeleg, mtvec, stvec;

  trap_arbiter #(.XLEN(XLEN), .PC_RESET(PC_RESET)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .bus(bus),
    .priv_i(priv), .mstatus_mie_i(m_mie), .mstatus_sie_i(m_sie),
    .mip_i(mip), .mie_i(mie), .mideleg_i(mideleg), .medeleg_i(medeleg),
    .mtvec_i(mtvec), .stvec_i(stvec)
  );

  typedef struct {
    int          cyc;
    bit          trap;
    bit          m;
    bit          s;
    bit          is_async;
    logic [63:0] pc;
    logic [63:0] tval;
    logic [63:0] cause;
    logic [63:0] rpc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   ack_en = 1'b1;
  int   prio [6] = '{11, 3, 7, 9, 1, 5};

  always @(posedge clk) cyc <= cyc + 1;

  function void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic bit irq_ok(int c);
    if (!(mip[c] && mie[c])) return 1'b0;
    if (mideleg[c]) return (priv == 2'd0) || (priv == 2'd1 && m_sie);
    return (priv != 2'd3) || m_mie;
  endfunction

  function automatic bit pick_irq(output int c);
    c = 0;
    for (int i = 0; i < 6; i++)
      if (irq_ok(prio[i])) begin
        c = prio[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [63:0] vec(bit to_s, bit is_async, int c);
    logic [63:0] t;
    logic [63:0] v;
    t = to_s ? stvec : mtvec;
    v = t - {62'd0, t[1:0]};
    if (is_async && t[1:0] == 2'b01) v = v + 64'(4 * c);
    return v;
  endfunction

  function automatic exp_t mk_trap(bit is_async, int c, bit to_s, logic [63:0] pc, logic [63:0] tval);
    exp_t e;
    e.cyc = cyc + 1; e.trap = 1'b1; e.m = !to_s; e.s = to_s; e.is_async = is_async;
    e.pc = pc; e.tval = tval; e.cause = 64'(c); e.rpc = vec(to_s, is_async, c);
    return e;
  endfunction

  function automatic exp_t mk_redir(logic [63:0] pc);
    exp_t e;
    e.cyc = cyc + 1; e.trap = 1'b0; e.m = 1'b0; e.s = 1'b0; e.is_async = 1'b0;
    e.pc = '0; e.tval = '0; e.cause = '0; e.rpc = pc;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic        prev_rv = 1'b0;
  logic [63:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!arst_ni) begin
      prev_rv <= 1'b0;
    end else begin
      if (bus.redirect_valid_o && !prev_rv) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_redirect: got redirect to %h expected none", bus.redirect_pc_o);
        end else begin
          e = q.pop_front();
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          chk("trap_valid", bus.trap_valid_o, e.trap);
          chk("ready_low_at_event", bus.commit_ready_o, 1'b0);
          if (e.trap) begin
            chk("trap_m", bus.trap_m_o, e.m);
            chk("trap_s", bus.trap_s_o, e.s);
            chk("trap_async", bus.trap_async_o, e.is_async);
            chk("trap_pc", bus.trap_pc_o, e.pc);
            chk("trap_value", bus.trap_value_o, e.tval);
            chk("trap_cause", bus.trap_cause_o, e.cause);
          end
          chk("redirect_pc", bus.redirect_pc_o, e.rpc);
        end
        held <= bus.redirect_pc_o;
      end else if (bus.redirect_valid_o) begin
        chk("redirect_pc_hold", bus.redirect_pc_o, held);
        chk("ready_low_in_flush", bus.commit_ready_o, 1'b0);
        if (bus.trap_valid_o) begin
          n_vec++; n_err++;
          $display("FAIL stray_trap_valid: got 1 expected 0");
        end
      end else if (bus.trap_valid_o) begin
        n_vec++; n_err++;
        $display("FAIL stray_trap_valid: got 1 expected 0");
      end
      prev_rv <= bus.redirect_valid_o;
    end
  end

  // ---------------- flush acknowledge ----------------
  initial begin
    bus.flush_ack_i = 1'b0;
    forever begin
      @(negedge clk); #1;
      bus.flush_ack_i = ack_en && bus.redirect_valid_o && ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic noise_commit();
    bus.commit_valid_i = 1'($urandom_range(0, 1));
    bus.commit_exc_i   = 1'($urandom_range(0, 1));
    bus.commit_wfi_i   = 1'($urandom_range(0, 1));
    bus.commit_cause_i = 6'($urandom);
    bus.commit_pc_i    = {$urandom, $urandom};
    bus.commit_tval_i  = {$urandom, $urandom};
  endtask

  task automatic clear_csr();
    priv = 2'd3; m_mie = 1'b0; m_sie = 1'b0;
    mip = '0; mie = '0; mideleg = '0; medeleg = '0; mtvec = '0; stvec = '0;
  endtask

  task automatic rand_csr();
    case ($urandom_range(0, 2))
      0:       priv = 2'd0;
      1:       priv = 2'd1;
      default: priv = 2'd3;
    endcase
    m_mie   = 1'($urandom_range(0, 1));
    m_sie   = 1'($urandom_range(0, 1));
    mip     = {$urandom, $urandom} & ~IRQ_BITS;
    if ($urandom_range(0, 2) == 0) mip = mip | (64'($urandom) & IRQ_BITS);
    mie     = {$urandom, $urandom};
    mideleg = {$urandom, $urandom};
    medeleg = {$urandom, $urandom};
    mtvec   = {$urandom, $urandom};
    stvec   = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && bus.commit_ready_o === 1'b1) && n < 40) begin
      noise_commit();
      mip = {$urandom, $urandom};
      mie = {$urandom, $urandom};
      tick();
      n++;
    end
    chk("back_to_run_in_time", 64'(n < 40), 64'd1);
    if (n >= 40) q.delete();
    bus.commit_valid_i = 1'b0;
  endtask

  task automatic do_commit(input bit exc, input bit wfi, input logic [5:0] cause,
                           input logic [63:0] pc, input logic [63:0] tval,
                           output bit slept);
    int c;
    bit is_none = 1'b0;
    slept = 1'b0;
    chk("ready_before_commit", bus.commit_ready_o, 1'b1);
    bus.commit_valid_i = 1'b1; bus.commit_exc_i = exc; bus.commit_wfi_i = wfi;
    bus.commit_cause_i = cause; bus.commit_pc_i = pc; bus.commit_tval_i = tval;
    if (pick_irq(c))  q.push_back(mk_trap(1'b1, c, mideleg[c], pc, '0));
    else if (exc)     q.push_back(mk_trap(1'b0, int'(cause), medeleg[cause] && priv != 2'd3, pc, tval));
    else if (wfi)     slept = 1'b1;
    else              is_none = 1'b1;
    tick();
    bus.commit_valid_i = 1'b0;
    if (is_none) begin
      chk("ready_after_plain_commit", bus.commit_ready_o, 1'b1);
      chk("no_sleep_after_plain_commit", bus.wfi_sleep_o, 1'b0);
    end else if (slept) begin
      chk("wfi_sleep_set", bus.wfi_sleep_o, 1'b1);
      chk("ready_low_in_wfi", bus.commit_ready_o, 1'b0);
    end else begin
      wait_idle();
    end
  endtask

  // Predicts and applies the WFI exit using the CSR values currently driven.
  task automatic wake_now(input logic [63:0] wake);
    int c;
    if (pick_irq(c)) q.push_back(mk_trap(1'b1, c, mideleg[c], wake, '0));
    else             q.push_back(mk_redir(wake));
    tick();
    chk("wfi_sleep_cleared", bus.wfi_sleep_o, 1'b0);
    wait_idle();
  endtask

  task automatic wfi_hold_random();
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      rand_csr();
      mip = {$urandom, $urandom};
      mie = {$urandom, $urandom} & ~mip;
      noise_commit();
      tick();
      chk("wfi_sleep_hold", bus.wfi_sleep_o, 1'b1);
      chk("wfi_ready_hold", bus.commit_ready_o, 1'b0);
    end
    bus.commit_valid_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          slept;
    logic [63:0] pc;
    int          b;

    bus.commit_valid_i = 1'b0; bus.commit_exc_i = 1'b0; bus.commit_wfi_i = 1'b0;
    bus.commit_cause_i = '0; bus.commit_pc_i = '0; bus.commit_tval_i = '0;
    clear_csr();

    tick(); tick();
    chk("rst_trap_valid", bus.trap_valid_o, 1'b0);
    chk("rst_trap_m", bus.trap_m_o, 1'b0);
    chk("rst_trap_s", bus.trap_s_o, 1'b0);
    chk("rst_trap_async", bus.trap_async_o, 1'b0);
    chk("rst_redirect_valid", bus.redirect_valid_o, 1'b0);
    chk("rst_redirect_pc", bus.redirect_pc_o, PC_RESET);
    chk("rst_wfi_sleep", bus.wfi_sleep_o, 1'b0);
    chk("rst_trap_pc", bus.trap_pc_o, '0);
    chk("rst_trap_value", bus.trap_value_o, '0);
    chk("rst_trap_cause", bus.trap_cause_o, '0);
    chk("rst_ready", bus.commit_ready_o, 1'b1);
    arst_ni = 1'b1;
    tick();

    // Delegated ecall from U to S.
    clear_csr(); priv = 2'd0; medeleg = 64'h100; stvec = 64'h8000_1000; mtvec = 64'h4000;
    do_commit(1'b1, 1'b0, 6'd8, 64'h1234, 64'hDEAD, slept);

    // Vectored MEI in M mode, MEI beats MSI/MTI.
    clear_csr(); priv = 2'd3; m_mie = 1'b1; mip = 64'h888; mie = 64'h888; mtvec = 64'h101;
    do_commit(1'b0, 1'b0, 6'd2, 64'h5000, 64'h77, slept);

    // Delegated STI pending in M: never taken, instruction just commits.
    clear_csr(); priv = 2'd3; m_mie = 1'b1; mideleg = 64'h222; mip = 64'h20; mie = 64'h20;
    do_commit(1'b0, 1'b0, 6'd0, 64'h6000, 64'h0, slept);

    // WFI woken by a masked MTI: plain redirect to PC+4.
    clear_csr(); priv = 2'd3;
    do_commit(1'b0, 1'b1, 6'd0, 64'h2000, 64'h0, slept);
    tick(); chk("wfi_idle_sleep", bus.wfi_sleep_o, 1'b1);
    mip = 64'h80; mie = 64'h80;
    wake_now(64'h2004);

    // WFI in S woken by a delegated, enabled SEI.
    clear_csr(); priv = 2'd1; m_sie = 1'b1; mideleg = 64'h200; stvec = 64'h9000;
    do_commit(1'b0, 1'b1, 6'd0, 64'h2000, 64'h0, slept);
    mip = 64'h200; mie = 64'h200;
    wake_now(64'h2004);

    // Exception and WFI together act as the exception.
    clear_csr(); priv = 2'd3; mtvec = 64'h301;
    do_commit(1'b1, 1'b1, 6'd2, 64'h7000, 64'h1111, slept);

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      rand_csr();
      pc = {$urandom, $urandom};
      do_commit(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                6'($urandom), pc, {$urandom, $urandom}, slept);
      if (slept) begin
        wfi_hold_random();
        rand_csr();
        b = prio[$urandom_range(0, 5)];
        mip[b] = 1'b1; mie[b] = 1'b1;
        noise_commit();
        wake_now(pc + 64'd4);
      end
    end

    // Reset asserted while the redirect is outstanding.
    ack_en = 1'b0;
    clear_csr(); priv = 2'd3; mtvec = 64'h300;
    bus.commit_valid_i = 1'b1; bus.commit_exc_i = 1'b1; bus.commit_wfi_i = 1'b0;
    bus.commit_cause_i = 6'd2; bus.commit_pc_i = 64'hA000; bus.commit_tval_i = 64'h5;
    q.push_back(mk_trap(1'b0, 2, 1'b0, 64'hA000, 64'h5));
    tick();
    bus.commit_valid_i = 1'b0;
    tick();
    chk("flush_redirect_held", bus.redirect_valid_o, 1'b1);
    arst_ni = 1'b0;
    #1;
    chk("async_rst_redirect_valid", bus.redirect_valid_o, 1'b0);
    chk("async_rst_redirect_pc", bus.redirect_pc_o, PC_RESET);
    chk("async_rst_trap_pc", bus.trap_pc_o, '0);
    chk("async_rst_trap_cause", bus.trap_cause_o, '0);
    chk("async_rst_ready", bus.commit_ready_o, 1'b1);
    tick(); tick();
    arst_ni = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_trap_valid", bus.trap_valid_o, 1'b0);
      chk("post_rst_redirect_valid", bus.redirect_valid_o, 1'b0);
      chk("post_rst_ready", bus.commit_ready_o, 1'b1);
    end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
